dot_tracker: RTL and testbench

- Owns the pellet map for the maze and produces `dots_left`, which the game-state FSM uses to detect a win.
- On reset or restart it loads the initial dot map from a 1-bit ROM, counting dots as it goes.
- While the game runs, it watches Pac-Man's centre cell and clears a dot when he reaches it, pulsing `dot_eaten` for the score path.
- It also answers per-pixel "is a dot here" queries from the renderer.

---
 rtl/dot_tracker.sv | 196 +++++++++++++++++++
 tb/tb_dot_tracker.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_tracker.sv
// dot_tracker: owns the pellet bitmap for the maze. After reset or restart it
// streams the initial dot map out of a 1-bit ROM while counting the dots. It
// then samples Pac-Man's centre cell every other cycle, eating the dot found
// there. It also answers registered per-pixel "dot here" queries for the
// renderer.
module dot_tracker #(
    parameter int GRID_W    = 26,
    parameter int GRID_H    = 29,
    parameter int CELL_LOG2 = 4,
    parameter int ADDR_W    = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              restart,
    input  logic              pause,
    input  logic [9:0]        pX,
    input  logic [9:0]        pY,
    input  logic [9:0]        pSize,
    output logic [ADDR_W-1:0] init_addr,
    input  logic              init_data,
    input  logic [9:0]        drawX,
    input  logic [9:0]        drawY,
    output logic              dot_here,
    output logic [31:0]       dots_left,
    output logic              dot_eaten,
    output logic              ready
);

    localparam int N    = GRID_W * GRID_H;
    localparam int CELL = 1 << CELL_LOG2;

    // The visible dot is a 4x4 square centred in the cell
    localparam logic [CELL_LOG2-1:0] DOT_LO = CELL_LOG2'(CELL / 2 - 2);
    localparam logic [CELL_LOG2-1:0] DOT_HI = CELL_LOG2'(CELL / 2 + 1);

    localparam logic [9:0]        GRID_W10  = 10'(GRID_W);
    localparam logic [9:0]        GRID_H10  = 10'(GRID_H);
    localparam logic [ADDR_W:0]   LOAD_LAST = (ADDR_W + 1)'(N);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    typedef enum logic [1:0] {INIT, SAMPLE, CHECK, DONE} state_t;

    state_t state;
    state_t next_state;

    logic [N-1:0]      bitmap;
    logic [ADDR_W:0]   load_cnt;
    logic [ADDR_W:0]   load_count;
    logic [ADDR_W:0]   count_final;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] idx_r;
    logic              in_range_r;

    logic [9:0]        cx;
    logic [9:0]        cy;
    logic [9:0]        col;
    logic [9:0]        row;
    logic              in_range;
    logic [ADDR_W-1:0] sample_idx;

    logic [9:0]        dcol;
    logic [9:0]        drow;
    logic              draw_in_range;
    logic              within_dot;
    logic [ADDR_W-1:0] draw_idx;

    logic clear;
    logic hit;
    logic load_write;
    logic load_done;
    logic take_sample;
    logic eat;

    assign clear = Reset | restart;

    // The load counter runs one past the last address; the ROM address holds at N-1
    assign init_addr   = (load_cnt < LOAD_LAST) ? load_cnt[ADDR_W-1:0] : LAST_ADDR;
    assign wr_idx      = load_cnt[ADDR_W-1:0] - ADDR_W'(1);
    assign count_final = load_count + {{ADDR_W{1'b0}}, init_data};
    assign hit         = in_range_r & bitmap[idx_r];

    // Pac-Man centre cell and renderer cell geometry, all in 10-bit wrapping arithmetic
    always_comb begin
        cx            = pX + (pSize >> 1);
        cy            = pY + (pSize >> 1);
        col           = cx >> CELL_LOG2;
        row           = cy >> CELL_LOG2;
        in_range      = (col < GRID_W10) && (row < GRID_H10);
        sample_idx    = ADDR_W'(row) * ADDR_W'(GRID_W) + ADDR_W'(col);
        dcol          = drawX >> CELL_LOG2;
        drow          = drawY >> CELL_LOG2;
        draw_in_range = (dcol < GRID_W10) && (drow < GRID_H10);
        draw_idx      = ADDR_W'(drow) * ADDR_W'(GRID_W) + ADDR_W'(dcol);
        within_dot    = (drawX[CELL_LOG2-1:0] >= DOT_LO) && (drawX[CELL_LOG2-1:0] <= DOT_HI) &&
                        (drawY[CELL_LOG2-1:0] >= DOT_LO) && (drawY[CELL_LOG2-1:0] <= DOT_HI);
    end

    // State register; reset and restart both land in INIT via next_state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the datapath strobes; a restart suppresses any eat this cycle
    always_comb begin
        next_state  = state;
        dot_eaten   = 1'b0;
        load_write  = 1'b0;
        load_done   = 1'b0;
        take_sample = 1'b0;
        eat         = 1'b0;
        if (clear) begin
            next_state = INIT;
        end else begin
            case (state)
                INIT: begin
                    load_write = (load_cnt != '0);
                    if (load_cnt == LOAD_LAST) begin
                        load_done  = 1'b1;
                        next_state = (count_final != '0) ? SAMPLE : DONE;
                    end
                end
                SAMPLE: begin
                    if (!pause) begin
                        take_sample = 1'b1;
                        next_state  = CHECK;
                    end
                end
                CHECK: begin
                    next_state = SAMPLE;
                    if (hit) begin
                        eat       = 1'b1;
                        dot_eaten = 1'b1;
                        if (dots_left == 32'd0) begin
                            next_state = DONE;
                        end
                    end
                end
                DONE: begin
                    next_state = DONE;
                end
                default: begin
                    next_state = INIT;
                end
            endcase
        end
    end

    // Map loading, centre sampling and dot consumption
    always_ff @(posedge Clk) begin
        if (clear) begin
            load_cnt   <= '0;
            load_count <= '0;
            bitmap     <= '0;
            dots_left  <= 32'd0;
            ready      <= 1'b0;
            idx_r      <= '0;
            in_range_r <= 1'b0;
        end else begin
            if (state == INIT && load_cnt != LOAD_LAST) begin
                load_cnt <= load_cnt + 1'b1;
            end
            if (load_write) begin
                bitmap[wr_idx] <= init_data;
                if (init_data) begin
                    load_count <= load_count + 1'b1;
                end
            end
            if (load_done) begin
                dots_left <= 32'(count_final) - 32'd1;
                ready     <= 1'b1;
            end
            if (take_sample) begin
                idx_r      <= sample_idx;
                in_range_r <= in_range;
            end
            if (eat) begin
                bitmap[idx_r] <= 1'b0;
                dots_left     <= dots_left - 32'd1;
            end
        end
    end

    // Renderer query, one cycle of latency, blanked until the map is loaded
    always_ff @(posedge Clk) begin
        if (clear) begin
            dot_here <= 1'b0;
        end else begin
            dot_here <= ready & draw_in_range & bitmap[draw_idx] & within_dot;
        end
    end

endmodule

// File: tb/tb_dot_tracker.sv
// tb_dot_tracker: randomized and directed stimulus for dot_tracker, checked
// every cycle against a behavioural model that tracks the pellet map, the
// remaining dot count and the load progress with plain arrays and integers.
module tb_dot_tracker;

    localparam int GRID_W    = 26;
    localparam int GRID_H    = 29;
    localparam int CELL_LOG2 = 4;
    localparam int ADDR_W    = 10;
    localparam int N         = GRID_W * GRID_H;
    localparam int CELL      = 1 << CELL_LOG2;

    logic              Clk       = 1'b0;
    logic              Reset     = 1'b1;
    logic              restart   = 1'b0;
    logic              pause     = 1'b1;
    logic [9:0]        pX        = '0;
    logic [9:0]        pY        = '0;
    logic [9:0]        pSize     = 10'd16;
    logic [9:0]        drawX     = '0;
    logic [9:0]        drawY     = '0;
    logic              init_data = 1'b0;
    logic [ADDR_W-1:0] init_addr;
    logic              dot_here;
    logic [31:0]       dots_left;
    logic              dot_eaten;
    logic              ready;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit checking = 1'b0;

    bit rom [N];

    // Behavioural model state
    bit m_loading = 1'b0;
    int m_cyc     = 0;
    bit m_ready   = 1'b0;
    int m_left    = 0;
    bit m_map [N];
    bit m_pending = 1'b0;
    int m_cell    = -1;
    bit m_dot_here = 1'b0;

    dot_tracker #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .CELL_LOG2(CELL_LOG2), .ADDR_W(ADDR_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .restart(restart), .pause(pause),
        .pX(pX), .pY(pY), .pSize(pSize),
        .init_addr(init_addr), .init_data(init_data),
        .drawX(drawX), .drawY(drawY),
        .dot_here(dot_here), .dots_left(dots_left),
        .dot_eaten(dot_eaten), .ready(ready)
    );

    always #5 Clk = ~Clk;

    // Synchronous 1-bit map ROM with one cycle of read latency
    always @(posedge Clk) init_data <= rom[int'(init_addr)];

    // Count every eat pulse seen by the sampling edge
    always @(negedge Clk) if (dot_eaten === 1'b1) pulses++;

    function automatic int centre_cell(input logic [9:0] x, input logic [9:0] y, input logic [9:0] s);
        int cx;
        int cy;
        cx = (int'(x) + int'(s) / 2) % 1024;
        cy = (int'(y) + int'(s) / 2) % 1024;
        if (cx / CELL < GRID_W && cy / CELL < GRID_H) return (cy / CELL) * GRID_W + cx / CELL;
        return -1;
    endfunction

    function automatic bit draw_dot(input logic [9:0] x, input logic [9:0] y);
        int c;
        int r;
        int ox;
        int oy;
        c  = int'(x) / CELL;
        r  = int'(y) / CELL;
        ox = int'(x) % CELL;
        oy = int'(y) % CELL;
        if (c >= GRID_W || r >= GRID_H) return 1'b0;
        if (ox < CELL / 2 - 2 || ox > CELL / 2 + 1 || oy < CELL / 2 - 2 || oy > CELL / 2 + 1) return 1'b0;
        return m_map[r * GRID_W + c];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic applyStimulus(input int x, input int y, input int s, input bit p, input int dx, input int dy);
        pX    = 10'(x);
        pY    = 10'(y);
        pSize = 10'(s);
        pause = p;
        drawX = 10'(dx);
        drawY = 10'(dy);
    endtask

    task automatic waitReady(output int cycles);
        cycles = 0;
        while (ready !== 1'b1 && cycles < 2000) begin
            tick();
            cycles++;
        end
        if (ready !== 1'b1) checkOutput("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic randomPosition();
        int x;
        int y;
        int s;
        s = int'($urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 1023));
        end else begin
            x = int'($urandom_range(0, GRID_W - 1)) * CELL + int'($urandom_range(0, 15)) - s / 2;
            y = int'($urandom_range(0, GRID_H - 1)) * CELL + int'($urandom_range(0, 15)) - s / 2;
            if (x < 0) x = 0;
            if (y < 0) y = 0;
        end
        applyStimulus(x, y, s, ($urandom_range(0, 7) == 0),
                      int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
    endtask

    // Reference model: advances on each clock edge from the pre-edge inputs
    always @(posedge Clk) begin
        if (Reset || restart) begin
            m_loading  = 1'b1;
            m_cyc      = 0;
            m_ready    = 1'b0;
            m_left     = 0;
            m_pending  = 1'b0;
            m_dot_here = 1'b0;
        end else begin
            m_dot_here = m_ready && draw_dot(drawX, drawY);
            if (m_loading) begin
                if (m_cyc == N) begin
                    m_loading = 1'b0;
                    m_ready   = 1'b1;
                    m_left    = 0;
                    for (int i = 0; i < N; i++) begin
                        m_map[i] = rom[i];
                        m_left += int'(rom[i]);
                    end
                end else begin
                    m_cyc++;
                end
            end else if (m_ready && m_left > 0) begin
                if (m_pending) begin
                    if (m_cell >= 0) begin
                        if (m_map[m_cell]) begin
                            m_map[m_cell] = 1'b0;
                            m_left--;
                        end
                    end
                    m_pending = 1'b0;
                end else if (!pause) begin
                    m_pending = 1'b1;
                    m_cell    = centre_cell(pX, pY, pSize);
                end
            end
        end
    end

    // Compare the DUT against the model on every falling edge once reset has been seen
    always @(negedge Clk) begin : compare
        bit exp_eat;
        if (checking) begin
            exp_eat = 1'b0;
            if (m_pending && !Reset && !restart && m_cell >= 0) exp_eat = m_map[m_cell];
            checkOutput("ready", 32'(ready), 32'(m_ready));
            checkOutput("dots_left", dots_left, m_ready ? 32'(m_left - 1) : 32'd0);
            checkOutput("dot_eaten", 32'(dot_eaten), 32'(exp_eat));
            checkOutput("dot_here", 32'(dot_here), 32'(m_dot_here));
            if (m_loading) checkOutput("init_addr", 32'(init_addr), 32'((m_cyc < N) ? m_cyc : N - 1));
        end
    end

    initial begin
        int cyc;
        int p0;
        int k;
        int cnt;
        logic [31:0] dl0;

        // Load a map with dots at 0, 5 and N-1 only
        for (int i = 0; i < N; i++) rom[i] = 1'b0;
        rom[0]     = 1'b1;
        rom[5]     = 1'b1;
        rom[N - 1] = 1'b1;
        applyStimulus(16, 0, 16, 1'b1, 0, 0);
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        checking = 1'b1;
        #2;
        Reset = 1'b0;
        waitReady(cyc);
        checkOutput("ready_latency", 32'(cyc), 32'(N + 1));
        checkOutput("load_dots_left", dots_left, 32'd2);

        // Renderer queries against a full cell 0
        applyStimulus(16, 0, 16, 1'b1, 8, 8);
        tick();
        checkOutput("draw_full", 32'(dot_here), 32'd1);
        applyStimulus(16, 0, 16, 1'b1, 2, 8);
        tick();
        checkOutput("draw_edge", 32'(dot_here), 32'd0);
        applyStimulus(16, 0, 16, 1'b1, 500, 8);
        tick();
        checkOutput("draw_outside", 32'(dot_here), 32'd0);

        // Eat cell 0 and dwell there
        p0 = pulses;
        applyStimulus(0, 0, 16, 1'b0, 0, 0);
        repeat (22) tick();
        checkOutput("eat_cell0_pulses", 32'(pulses - p0), 32'd1);
        checkOutput("eat_cell0_left", dots_left, 32'd1);
        applyStimulus(0, 0, 16, 1'b0, 8, 8);
        tick();
        checkOutput("draw_eaten", 32'(dot_here), 32'd0);

        // Clear the remaining dots at cells 5 and N-1
        applyStimulus(80, 0, 16, 1'b0, 0, 0);
        repeat (6) tick();
        applyStimulus(400, 448, 16, 1'b0, 0, 0);
        repeat (6) tick();
        checkOutput("all_eaten_left", dots_left, 32'hFFFF_FFFF);
        checkOutput("all_eaten_pulses", 32'(pulses - p0), 32'd3);
        p0 = pulses;
        for (int i = 0; i < 30; i++) begin
            randomPosition();
            tick();
        end
        checkOutput("done_no_pulse", 32'(pulses - p0), 32'd0);
        checkOutput("done_ready", 32'(ready), 32'd1);

        // Random map; restart partway through the load
        cnt = 0;
        for (int i = 0; i < N; i++) rom[i] = ($urandom_range(0, 1) == 1);
        rom[100] = 1'b1;
        for (int i = 0; i < N; i++) cnt += int'(rom[i]);
        applyStimulus(352, 48, 16, 1'b1, 0, 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        k = 0;
        while (init_addr != ADDR_W'(300) && k < 2000) begin
            tick();
            k++;
        end
        checkOutput("reach_addr300", 32'(init_addr), 32'd300);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checkOutput("restart_addr", 32'(init_addr), 32'd0);
        checkOutput("restart_ready", 32'(ready), 32'd0);
        checkOutput("restart_left", dots_left, 32'd0);
        waitReady(cyc);
        checkOutput("reload_latency", 32'(cyc), 32'(N + 1));
        checkOutput("reload_left", dots_left, 32'(cnt - 1));

        // Paused on a dot: nothing eaten until released
        p0  = pulses;
        dl0 = dots_left;
        repeat (50) tick();
        checkOutput("pause_pulses", 32'(pulses - p0), 32'd0);
        checkOutput("pause_left", dots_left, dl0);
        pause = 1'b0;
        k = 0;
        while (pulses == p0 && k < 2) begin
            tick();
            k++;
        end
        checkOutput("unpause_eat", 32'(pulses - p0), 32'd1);

        // Empty map goes straight to the won state
        for (int i = 0; i < N; i++) rom[i] = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        waitReady(cyc);
        checkOutput("empty_left", dots_left, 32'hFFFF_FFFF);
        p0 = pulses;
        for (int i = 0; i < 20; i++) begin
            randomPosition();
            tick();
        end
        checkOutput("empty_no_pulse", 32'(pulses - p0), 32'd0);

        // Free-running random play with occasional restarts
        for (int i = 0; i < N; i++) rom[i] = ($urandom_range(0, 4) != 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        waitReady(cyc);
        for (int i = 0; i < 4000; i++) begin
            randomPosition();
            restart = ($urandom_range(0, 799) == 0);
            tick();
        end
        restart = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
